conv_stream_host: RTL and testbench
===================================

Name: conv_stream_host

Overview:
- Host-side driver for the convolution/pooling top: the transmitter for its image/weight load interface and the receiver for its pooled-result interface.
- Buffers an IMG x IMG signed 16-bit image written by the system side, then issues the weight-load pulse and the image-load pulse, and streams the pixels row-major, one per cycle.
- Captures every pooled word into a result buffer that the system side reads back.
- Sits between the system bus/testbench and the conv top, one instance per conv top.

Parameters:
IMG, 7, image edge length (pixels per row/column, unpadded)
N_OUT, 9, pooled words expected per frame
PIX_AW, 6, pixel buffer address width (2**PIX_AW >= IMG*IMG)
RES_AW, 4, result buffer address width (2**RES_AW >= N_OUT)
TIMEOUT, 1024, max cycles between consecutive pooled words (or stream end and first word) in COLLECT before error

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
pix_wr_en  in  1  write pixel buffer (accepted only when busy=0)
pix_wr_addr  in  PIX_AW  pixel index, row-major
pix_wr_data  in  16  signed pixel
start  in  1  single-cycle frame start (accepted only in IDLE)
w_load  out  1  single-cycle weight-load pulse to conv top
i_load  out  1  single-cycle image-load pulse to conv top
img_out  out  16  signed pixel stream to conv top img_in
pool_in  in  16  pooled word from conv top
pool_valid  in  1  qualifies pool_in (conv top done_pooling)
res_rd_addr  in  RES_AW  result read index
res_rd_data  out  16  result word, 1-cycle read latency
res_count  out  RES_AW+1  words captured this frame
busy  out  1  high in WLOAD/ILOAD/STREAM/COLLECT
done  out  1  sticky, N_OUT words captured; cleared by accepted start or rst
err  out  1  sticky, timeout; cleared by accepted start or rst
ovf  out  1  sticky, pool_valid seen with res_count==N_OUT; cleared by accepted start or rst

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Pixel and result buffer contents are not cleared. Reset mid-frame aborts immediately; no further pulses are issued.
- FSM states: IDLE, WLOAD, ILOAD, STREAM, COLLECT, DONE, ERR.
- IDLE: start=1 -> WLOAD. Same edge clears done/err/ovf and res_count.
- WLOAD: w_load=1 for exactly this cycle -> ILOAD.
- ILOAD: i_load=1 for exactly this cycle -> STREAM.
- STREAM: img_out=pix[k] for k=0..IMG*IMG-1, one per cycle, no gaps.
  - With start accepted at edge 0: w_load is high in cycle 1, i_load in cycle 2, pix[0] in cycle 3, last pixel in cycle 2+IMG*IMG.
  - After the last pixel -> COLLECT.
  - img_out=0 in every non-STREAM cycle.
- Capture rule (STREAM and COLLECT):
  - pool_valid=1 and res_count<N_OUT: write pool_in to res[res_count], then res_count+1.
  - pool_valid=1 and res_count==N_OUT: word dropped, ovf set.
- COLLECT:
  - Timeout counter resets on each captured word and on entry.
  - res_count reaches N_OUT -> DONE (done=1 from the cycle after the last capture edge). This also applies if the Nth word arrives during STREAM; the FSM goes from STREAM to DONE after the last pixel.
  - Counter reaches TIMEOUT without a word -> ERR, err=1.
- DONE/ERR: busy=0. start -> WLOAD, as from IDLE. pool_valid in DONE sets ovf; res_count is not changed.
- start while busy: ignored, no effect.
- pix_wr_en while busy: ignored. Writes in the same cycle as an accepted start are ignored.
- pix_wr_addr >= IMG*IMG: ignored.
- Result read: res_rd_data = res[res_rd_addr] registered, valid one cycle after the address is presented, in any state. Reading and capturing the same index in the same cycle returns the old value.
- pool_in is taken unmodified; no arithmetic or saturation is applied.

Test Plan:
- Load pix[k]=k (0..48), pulse start at cycle 0 -> w_load=1 only in cycle 1; i_load=1 only in cycle 2; img_out=0,1,...,48 in cycles 3..51; busy drops after last capture.
- After stream, drive pool_valid with words 100..108 on 9 spaced cycles -> res_count=9, done=1, err=0; reads of addr 0..8 return 100..108 one cycle after each address.
- Drive 10 pool_valid pulses (10th word 0xFFFF) -> ovf=1, res[8] keeps 108, res_count=9.
- Deliver 3 words then stall 1024 cycles -> err=1, done=0, busy=0; a new start clears err and res_count to 0.
- Pulse start in cycle 20 of the stream and write pix_wr_en to addr 5 mid-frame -> no second w_load/i_load; the stream is unchanged; pix[5] keeps its old value on the next frame.
- Assert rst in cycle 30 of the stream -> next cycle img_out=0, busy=0, done/err/ovf=0, FSM in IDLE; a subsequent start replays the full 1/2/3.. timing.

Source files
------------

// File: rtl/conv_stream_host.sv
// Host-side driver for the conv/pooling top: buffers one image, issues the
// weight/image load pulses, streams pixels row-major and captures pooled words.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; pixel buffer writable
// WLOAD   | single-cycle weight-load pulse
// ILOAD   | single-cycle image-load pulse
// STREAM  | one pixel per cycle on img_out, pooled words captured
// COLLECT | waiting for remaining pooled words under a timeout
// DONE    | all pooled words captured; restartable
// ERR     | timeout between pooled words; restartable
module conv_stream_host #(
    parameter int IMG     = 7,
    parameter int N_OUT   = 9,
    parameter int PIX_AW  = 6,
    parameter int RES_AW  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_wr_en,
    input  logic [PIX_AW-1:0] pix_wr_addr,
    input  logic [15:0]       pix_wr_data,
    input  logic              start,
    output logic              w_load,
    output logic              i_load,
    output logic [15:0]       img_out,
    input  logic [15:0]       pool_in,
    input  logic              pool_valid,
    input  logic [RES_AW-1:0] res_rd_addr,
    output logic [15:0]       res_rd_data,
    output logic [RES_AW:0]   res_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    localparam int NPIX = IMG * IMG;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [PIX_AW:0]   NPIX_C   = (PIX_AW + 1)'(NPIX);
    localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NPIX - 1);
    localparam logic [RES_AW:0]   N_OUT_C  = (RES_AW + 1)'(N_OUT);
    localparam logic [RES_AW:0]   N_OUT_M1 = (RES_AW + 1)'(N_OUT - 1);
    localparam logic [TW-1:0]     TMR_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_ILOAD, S_STREAM, S_COLLECT, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [PIX_AW-1:0] pix_idx;
    logic [TW-1:0]     tmr;
    logic [15:0]       pix_mem [2**PIX_AW];
    logic [15:0]       res_mem [2**RES_AW];

    logic start_ok, capture_win, capture, full_nxt, pix_we;

    assign start_ok    = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign capture_win = (state == S_STREAM) || (state == S_COLLECT);
    assign capture     = capture_win && pool_valid && (res_count < N_OUT_C);
    // true if the result buffer will be complete after this edge
    assign full_nxt    = (res_count == N_OUT_C) || (capture && res_count == N_OUT_M1);
    assign pix_we      = pix_wr_en && !rst && !busy && !start_ok && ({1'b0, pix_wr_addr} < NPIX_C);

    assign busy    = (state == S_WLOAD) || (state == S_ILOAD) || capture_win;
    assign done    = (state == S_DONE);
    assign err     = (state == S_ERR);
    assign w_load  = (state == S_WLOAD);
    assign i_load  = (state == S_ILOAD);
    assign img_out = (state == S_STREAM) ? pix_mem[pix_idx] : 16'd0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_WLOAD;
            S_WLOAD:               state_nxt = S_ILOAD;
            S_ILOAD:               state_nxt = S_STREAM;
            S_STREAM: begin
                if (pix_idx == LAST_PIX) state_nxt = full_nxt ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                if (full_nxt)                   state_nxt = S_DONE;
                else if (!capture && tmr == '0) state_nxt = S_ERR;
            end
            default:               state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pix_idx   <= '0;
            tmr       <= '0;
            res_count <= '0;
            ovf       <= 1'b0;
        end else begin
            state   <= state_nxt;
            pix_idx <= (state == S_STREAM) ? pix_idx + 1'b1 : '0;

            if (start_ok)     res_count <= '0;
            else if (capture) res_count <= res_count + 1'b1;

            if (start_ok)
                ovf <= 1'b0;
            else if (pool_valid && res_count == N_OUT_C && (capture_win || state == S_DONE))
                ovf <= 1'b1;

            // timeout down-counter reloads outside COLLECT and on every captured word
            if (state != S_COLLECT || capture) tmr <= TMR_LOAD;
            else if (tmr != '0)                tmr <= tmr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_we)  pix_mem[pix_wr_addr] <= pix_wr_data;
        if (capture) res_mem[res_count[RES_AW-1:0]] <= pool_in;
    end

    always_ff @(posedge clk) begin
        if (rst) res_rd_data <= 16'd0;
        else     res_rd_data <= res_mem[res_rd_addr];
    end

endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host: frame-cycle reference model checked
// every cycle, plus hand-computed checkpoints for timing and flag behaviour.
module tb_conv_stream_host;

    localparam int IMG     = 7;
    localparam int N_OUT   = 9;
    localparam int PIX_AW  = 6;
    localparam int RES_AW  = 4;
    localparam int TIMEOUT = 1024;
    localparam int NPIX    = IMG * IMG;

    logic              clk = 1'b0;
    logic              rst, start, pix_wr_en, pool_valid;
    logic [PIX_AW-1:0] pix_wr_addr;
    logic [15:0]       pix_wr_data, pool_in, img_out, res_rd_data;
    logic [RES_AW-1:0] res_rd_addr;
    logic [RES_AW:0]   res_count;
    logic              w_load, i_load, busy, done, err, ovf;

    always #5 clk = ~clk;

    conv_stream_host #(
        .IMG(IMG), .N_OUT(N_OUT), .PIX_AW(PIX_AW), .RES_AW(RES_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
        .start(start), .w_load(w_load), .i_load(i_load), .img_out(img_out),
        .pool_in(pool_in), .pool_valid(pool_valid),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data), .res_count(res_count),
        .busy(busy), .done(done), .err(err), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model: m_fc is the cycle index inside the current frame (0 = no frame)
    logic [15:0] m_pix [NPIX];
    logic [15:0] m_res [2**RES_AW];
    bit          m_res_known [2**RES_AW];
    int          m_fc = 0, m_count = 0, m_idle = 0;
    bit          m_done = 0, m_err = 0, m_ovf = 0, m_rd_known = 0;
    logic [15:0] m_rd = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return m_fc != 0 && !m_done && !m_err;
    endfunction

    task automatic model_step();
        bit busy_now, cap;
        busy_now = m_busy();
        if (rst) begin
            m_fc = 0; m_count = 0; m_idle = 0;
            m_done = 0; m_err = 0; m_ovf = 0;
            m_rd = 16'd0; m_rd_known = 1;
            return;
        end
        m_rd       = m_res[res_rd_addr];
        m_rd_known = m_res_known[res_rd_addr];
        if (start && !busy_now) begin
            m_fc = 1; m_count = 0; m_idle = 0;
            m_done = 0; m_err = 0; m_ovf = 0;
            return;
        end
        if (!busy_now && pix_wr_en && int'(pix_wr_addr) < NPIX)
            m_pix[pix_wr_addr] = pix_wr_data;
        cap = 0;
        if (busy_now && m_fc >= 3 && pool_valid) begin
            if (m_count < N_OUT) begin
                m_res[m_count] = pool_in;
                m_res_known[m_count] = 1;
                m_count++;
                m_idle = 0;
                cap = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_done && pool_valid) begin
            m_ovf = 1;
        end
        if (busy_now) begin
            if (m_fc > 2 + NPIX && !cap) m_idle++;
            m_fc++;
            if (m_fc > 2 + NPIX && m_count == N_OUT) m_done = 1;
            else if (m_idle == TIMEOUT)              m_err = 1;
        end
    endtask

    task automatic compare_all();
        bit b;
        logic [15:0] img_e;
        b = m_busy();
        img_e = (b && m_fc >= 3 && m_fc <= 2 + NPIX) ? m_pix[m_fc-3] : 16'd0;
        chk("w_load",    w_load,    b && m_fc == 1);
        chk("i_load",    i_load,    b && m_fc == 2);
        chk("img_out",   img_out,   img_e);
        chk("busy",      busy,      b);
        chk("done",      done,      m_done);
        chk("err",       err,       m_err);
        chk("ovf",       ovf,       m_ovf);
        chk("res_count", res_count, m_count);
        if (m_rd_known) chk("res_rd_data", res_rd_data, m_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; pix_wr_en = 1'b0; pix_wr_addr = '0; pix_wr_data = '0;
        pool_valid = 1'b0; pool_in = '0; res_rd_addr = '0;
        for (int i = 0; i < 2**RES_AW; i++) m_res_known[i] = 0;
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); if (chk_en) compare_all(); end
        join_none

        tick(); tick();
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_img", img_out, 0);
        chk("rst_count", res_count, 0);
        rst = 1'b0;

        for (int k = 0; k < NPIX; k++) begin
            pix_wr_en = 1'b1; pix_wr_addr = PIX_AW'(k); pix_wr_data = 16'(k);
            tick();
        end
        pix_wr_addr = 6'd49; pix_wr_data = 16'hDEAD;
        tick();
        pix_wr_en = 1'b0;

        // frame 1: timing, capture, readback, overflow
        pulse_start();
        chk("f1_wload_c1", w_load, 1); chk("f1_iload_c1", i_load, 0);
        tick();
        chk("f1_iload_c2", i_load, 1); chk("f1_wload_c2", w_load, 0);
        tick(); chk("f1_img_c3", img_out, 0);
        tick(); chk("f1_img_c4", img_out, 1);
        repeat (47) tick();
        chk("f1_img_c51", img_out, 48);
        tick();
        chk("f1_img_c52", img_out, 0); chk("f1_busy_c52", busy, 1);
        for (int i = 0; i < N_OUT; i++) begin
            pool_valid = 1'b1; pool_in = 16'(100 + i);
            tick();
            pool_valid = 1'b0;
            tick(); tick();
        end
        chk("f1_done", done, 1); chk("f1_count", res_count, 9);
        chk("f1_err", err, 0);   chk("f1_busy", busy, 0);
        for (int i = 0; i < N_OUT; i++) begin
            res_rd_addr = RES_AW'(i);
            tick();
            chk("f1_read", res_rd_data, 100 + i);
        end
        pool_valid = 1'b1; pool_in = 16'hFFFF;
        tick();
        pool_valid = 1'b0;
        chk("f1_ovf", ovf, 1); chk("f1_count_ovf", res_count, 9);
        res_rd_addr = 4'd8;
        tick();
        chk("f1_res8_kept", res_rd_data, 108);

        // frame 2: three words then timeout
        pulse_start();
        chk("f2_count_clr", res_count, 0); chk("f2_ovf_clr", ovf, 0); chk("f2_done_clr", done, 0);
        repeat (51) tick();
        for (int i = 0; i < 3; i++) begin
            pool_valid = 1'b1; pool_in = 16'(200 + i);
            tick();
            pool_valid = 1'b0;
            if (i < 2) tick();
        end
        chk("f2_count3", res_count, 3);
        w = 0;
        while (err !== 1'b1 && w < 1100) begin
            tick();
            w++;
        end
        chk("f2_timeout_len", w, 1024);
        chk("f2_err", err, 1); chk("f2_done", done, 0); chk("f2_busy", busy, 0);
        pulse_start();
        chk("f3_err_clr", err, 0); chk("f3_count_clr", res_count, 0); chk("f3_busy", busy, 1);

        // frame 3: start and pixel write while busy; all words arrive during STREAM
        repeat (19) tick();
        start = 1'b1; pix_wr_en = 1'b1; pix_wr_addr = 6'd5; pix_wr_data = 16'h7777;
        tick();
        start = 1'b0; pix_wr_en = 1'b0;
        chk("f3_no_wload", w_load, 0); chk("f3_no_iload", i_load, 0);
        repeat (4) tick();
        pool_valid = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            pool_in = 16'(300 + i);
            tick();
        end
        pool_valid = 1'b0;
        chk("f3_count9", res_count, 9); chk("f3_done_early", done, 0);
        repeat (17) tick();
        chk("f3_img_c51", img_out, 48); chk("f3_done_c51", done, 0);
        tick();
        chk("f3_done_c52", done, 1); chk("f3_busy_c52", busy, 0);

        // frame 4: write with accepted start ignored, reset mid-stream
        start = 1'b1; pix_wr_en = 1'b1; pix_wr_addr = 6'd0; pix_wr_data = 16'h1234;
        tick();
        start = 1'b0; pix_wr_en = 1'b0;
        repeat (2) tick();
        chk("f4_pix0_kept", img_out, 0);
        repeat (5) tick();
        chk("f4_pix5_kept", img_out, 5);
        repeat (22) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_img_mid", img_out, 0); chk("rst_busy_mid", busy, 0);
        chk("rst_done_mid", done, 0);   chk("rst_err_mid", err, 0);
        chk("rst_ovf_mid", ovf, 0);     chk("rst_wload_mid", w_load, 0);

        pulse_start();
        chk("f5_wload_c1", w_load, 1);
        tick(); chk("f5_iload_c2", i_load, 1);
        tick(); chk("f5_img_c3", img_out, 0);
        tick(); chk("f5_img_c4", img_out, 1);
        repeat (47) tick();
        pool_valid = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            pool_in = 16'(400 + i);
            tick();
        end
        pool_valid = 1'b0;
        tick();
        chk("f5_done", done, 1);
        res_rd_addr = 4'd0;
        tick();
        chk("f5_read0", res_rd_data, 400);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
